// File: rtl/bus_router_if.sv
// Master-to-slave routing bus bundle for bus_router: master side, decoder inputs and the
// fan-out slave side. The router connects through the slave modport.
interface bus_router_if;
  logic         m_cyc_i;
  logic         m_stb_i;
  logic         m_we_i;
  logic [3:0]   m_sel_i;
  logic [31:0]  m_adr_i;
  logic [31:0]  m_dat_i;
  logic [3:0]   chipselect;
  logic         fault;
  logic [31:0]  m_dat_o;
  logic         m_ack_o;
  logic         m_err_o;
  logic [15:0]  s_cyc_o;
  logic [15:0]  s_stb_o;
  logic         s_we_o;
  logic [3:0]   s_sel_o;
  logic [31:0]  s_adr_o;
  logic [31:0]  s_dat_o;
  logic [511:0] s_dat_i;
  logic [15:0]  s_ack_i;
  logic         busy;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, chipselect, fault,
    input  s_dat_i, s_ack_i,
    output m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    output busy
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, chipselect, fault,
    output s_dat_i, s_ack_i,
    input  m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    input  busy
  );
endinterface

// File: rtl/bus_router.sv
// Single-master to 16-slave bus router: strobes the decoded slave, waits for its ack
// with a timeout, and answers the master with exactly one ack or err cycle.
module bus_router #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic         clk_i,
  input logic         rst_i,
  bus_router_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StActive, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] dat_q, dat_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        sel_ack;

  assign sel_ack = bus.s_ack_i[sel_q];

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    dat_d   = dat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.m_cyc_i && bus.m_stb_i) begin
          if (bus.fault || (bus.chipselect == 4'd0)) begin
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            sel_d   = bus.chipselect;
            cnt_d   = 8'd0;
            state_d = StActive;
          end
        end
      end
      StActive: begin
        // Master abandoning the cycle wins over any ack arriving in the same cycle.
        if (!bus.m_cyc_i) begin
          state_d = StIdle;
        end else if (sel_ack) begin
          dat_d   = bus.s_dat_i[{sel_q, 5'b0} +: 32];
          ack_d   = 1'b1;
          state_d = StResp;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      sel_q   <= 4'd0;
      cnt_q   <= 8'd0;
      dat_q   <= 32'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign bus.m_dat_o = dat_q;
  assign bus.m_ack_o = ack_q;
  assign bus.m_err_o = err_q;
  assign bus.busy    = (state_q != StIdle);
  assign bus.s_cyc_o = (state_q == StActive) ? (16'h0001 << sel_q) : 16'h0000;
  assign bus.s_stb_o = (state_q == StActive) ? (16'h0001 << sel_q) : 16'h0000;
  assign bus.s_we_o  = bus.m_we_i;
  assign bus.s_sel_o = bus.m_sel_i;
  assign bus.s_adr_o = bus.m_adr_i;
  assign bus.s_dat_o = bus.m_dat_i;

endmodule

// File: tb/tb_bus_router.sv
// Bench for bus_router: directed scenarios then random transactions, each predicted
// from the transaction rules (ack slot, abort slot, timeout length) at cycle level.
module tb_bus_router;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_dat = 32'd0;

  bus_router_if bif ();

  bus_router #(.TIMEOUT(TO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(bif.busy), 32'd0);
    chk({tag, "_ack"}, 32'(bif.m_ack_o), 32'd0);
    chk({tag, "_err"}, 32'(bif.m_err_o), 32'd0);
    chk({tag, "_stb"}, 32'(bif.s_stb_o), 32'd0);
    chk({tag, "_cyc"}, 32'(bif.s_cyc_o), 32'd0);
    chk({tag, "_dat"}, bif.m_dat_o, exp_dat);
  endtask

  task automatic rand_sdat();
    for (int k = 0; k < 16; k++) bif.s_dat_i[k*32 +: 32] = $urandom;
  endtask

  // ack_at / abort_at: ACTIVE-cycle index (0 = first) of selected ack / m_cyc_i drop; -1 none.
  task automatic txn(input logic [3:0] cs, input logic flt, input int ack_at, input int abort_at,
                     input logic [15:0] stray, input logic [31:0] fixed, input bit use_fixed);
    logic [15:0] onehot;
    bit          done;
    bit          aborted;
    bif.m_cyc_i    = 1'b1;
    bif.m_stb_i    = 1'b1;
    bif.m_we_i     = 1'($urandom);
    bif.m_sel_i    = 4'($urandom);
    bif.m_adr_i    = $urandom;
    bif.m_dat_i    = $urandom;
    bif.chipselect = cs;
    bif.fault      = flt;
    bif.s_ack_i    = 16'h0000;
    #1;
    chk("pass_adr", bif.s_adr_o, bif.m_adr_i);
    chk("pass_dat", bif.s_dat_o, bif.m_dat_i);
    chk("pass_selwe", {27'd0, bif.s_sel_o, bif.s_we_o}, {27'd0, bif.m_sel_i, bif.m_we_i});
    step();
    aborted = 1'b0;
    if (flt || cs == 4'd0) begin
      chk("fault_err", 32'(bif.m_err_o), 32'd1);
      chk("fault_ack", 32'(bif.m_ack_o), 32'd0);
      chk("fault_stb", 32'(bif.s_stb_o), 32'd0);
      chk("fault_dat", bif.m_dat_o, exp_dat);
      chk("fault_busy", 32'(bif.busy), 32'd1);
    end else begin
      onehot = 16'h0001 << cs;
      done   = 1'b0;
      for (int i = 0; i < TO && !done; i++) begin
        chk("act_stb", 32'(bif.s_stb_o), 32'(onehot));
        chk("act_cyc", 32'(bif.s_cyc_o), 32'(onehot));
        chk("act_resp", {30'd0, bif.m_ack_o, bif.m_err_o}, 32'd0);
        chk("act_busy", 32'(bif.busy), 32'd1);
        rand_sdat();
        bif.s_ack_i = stray & ~onehot;
        if (i == ack_at) begin
          bif.s_ack_i = bif.s_ack_i | onehot;
          if (use_fixed) bif.s_dat_i[cs*32 +: 32] = fixed;
        end
        if (i == abort_at) begin
          bif.m_cyc_i = 1'b0;
          bif.m_stb_i = 1'b0;
        end
        step();
        if (i == abort_at) begin
          chk_idle("abort");
          aborted = 1'b1;
          done    = 1'b1;
        end else if (i == ack_at) begin
          exp_dat = bif.s_dat_i[cs*32 +: 32];
          chk("ack_ack", 32'(bif.m_ack_o), 32'd1);
          chk("ack_err", 32'(bif.m_err_o), 32'd0);
          chk("ack_dat", bif.m_dat_o, exp_dat);
          chk("ack_stb", 32'(bif.s_stb_o), 32'd0);
          done = 1'b1;
        end else if (i == TO - 1) begin
          chk("to_err", 32'(bif.m_err_o), 32'd1);
          chk("to_ack", 32'(bif.m_ack_o), 32'd0);
          chk("to_dat", bif.m_dat_o, exp_dat);
          done = 1'b1;
        end
      end
      if (aborted) bif.s_ack_i = onehot;  // late ack after abort must be ignored
      else bif.s_ack_i = 16'h0000;
    end
    // Strobe still held through the response cycle: must not start a new transfer.
    step();
    chk_idle("post");
    bif.m_cyc_i = 1'b0;
    bif.m_stb_i = 1'b0;
    bif.s_ack_i = 16'h0000;
  endtask

  initial begin
    bif.m_cyc_i    = 1'b0;
    bif.m_stb_i    = 1'b0;
    bif.m_we_i     = 1'b0;
    bif.m_sel_i    = 4'h0;
    bif.m_adr_i    = 32'd0;
    bif.m_dat_i    = 32'd0;
    bif.chipselect = 4'd0;
    bif.fault      = 1'b0;
    bif.s_dat_i    = '0;
    bif.s_ack_i    = 16'h0000;
    step();
    step();
    chk_idle("reset");
    rst = 1'b0;
    step();

    // Read from slave 7, acked on the 2nd ACTIVE cycle.
    txn(4'd7, 1'b0, 1, -1, 16'h0000, 32'hDEADBEEF, 1'b1);
    chk("read_dat", bif.m_dat_o, 32'hDEADBEEF);
    // Decoder fault / no slave.
    txn(4'd0, 1'b1, -1, -1, 16'h0000, 32'd0, 1'b0);
    txn(4'd9, 1'b1, 0, -1, 16'hFFFF, 32'd0, 1'b0);
    // Timeout on slave 5.
    txn(4'd5, 1'b0, -1, -1, 16'h0000, 32'd0, 1'b0);
    // Stray ack from slave 10 while slave 2 selected, then slave 2 acks.
    txn(4'd2, 1'b0, 3, -1, 16'h0400, 32'h12345678, 1'b1);
    // Abort by m_cyc_i drop, with a simultaneous selected ack.
    txn(4'd4, 1'b0, 1, 1, 16'h0000, 32'd0, 1'b0);
    // Ack in the cycle the counter reaches TIMEOUT-1.
    txn(4'd15, 1'b0, TO - 1, -1, 16'h0000, 32'hA5A55A5A, 1'b1);

    for (int n = 0; n < 40; n++) begin
      txn(4'($urandom_range(0, 15)), 1'($urandom_range(0, 7) == 0),
          int'($urandom_range(0, TO + 3)),
          ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, TO - 1)) : -1,
          16'($urandom), 32'd0, 1'b0);
      if ($urandom_range(0, 1) == 1) step();
    end

    // Reset mid-transfer.
    bif.m_cyc_i    = 1'b1;
    bif.m_stb_i    = 1'b1;
    bif.chipselect = 4'd3;
    bif.fault      = 1'b0;
    step();
    chk("rst_pre_stb", 32'(bif.s_stb_o), 32'h0008);
    rst         = 1'b1;
    bif.s_ack_i = 16'h0008;
    step();
    exp_dat = 32'd0;
    chk_idle("rst_mid");
    rst         = 1'b0;
    bif.m_cyc_i = 1'b0;
    bif.m_stb_i = 1'b0;
    bif.s_ack_i = 16'h0000;
    step();
    chk_idle("rst_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_router.md
BUS_ROUTER -- requirements
Module: bus_router

Interface
REQ-001 Parameter: TIMEOUT, default 16, cycles a selected slave is given to ack before the router answers with an error; legal range 2..255.
REQ-002 clk_i  in  1  system clock; all state changes on the rising edge.
REQ-003 rst_i  in  1  reset, synchronous and active-high.
REQ-004 m_cyc_i, m_stb_i, m_we_i  in  1 each  master bus cycle, strobe and write enable.
REQ-005 m_sel_i  in  4  byte lanes; m_adr_i  in  32  address; m_dat_i  in  32  write data.
REQ-006 chipselect  in  4  slave index from the address decoder; 0 means no slave.
REQ-007 fault  in  1  decoder fault for the current address.
REQ-008 m_dat_o  out  32  read data; m_ack_o  out  1  normal completion; m_err_o  out  1  error completion.
REQ-009 s_cyc_o, s_stb_o  out  16 each  one-hot slave cycle and strobe, bit n serving chipselect n.
REQ-010 s_we_o  out  1;  s_sel_o  out  4;  s_adr_o  out  32;  s_dat_o  out  32  shared slave request buses, combinational copies of the master inputs.
REQ-011 s_dat_i  in  512  slave read data, slave n on bits [32n+31:32n]; s_ack_i  in  16  slave acks, bit n from slave n.
REQ-012 busy  out  1  high while the state is not IDLE.

Function
REQ-013 The router SHALL use three states: IDLE, ACTIVE and RESP.
REQ-014 In IDLE with m_cyc_i=1 and m_stb_i=1, when fault=1 or chipselect=0, the router SHALL go to RESP with the error flag set and SHALL not strobe any slave.
REQ-015 In IDLE with m_cyc_i=1 and m_stb_i=1, when fault=0 and chipselect=n≠0, the router SHALL latch n into sel_q, clear the timeout counter and go to ACTIVE.
REQ-016 In ACTIVE, s_cyc_o and s_stb_o SHALL be one-hot at bit sel_q, and all other bits SHALL be 0.
REQ-017 In IDLE and RESP, s_cyc_o and s_stb_o SHALL be 16'h0000.
REQ-018 In ACTIVE, when s_ack_i[sel_q]=1, the router SHALL capture s_dat_i slice sel_q into m_dat_o and go to RESP with the error flag clear.
REQ-019 Acks from unselected slaves SHALL be ignored.
REQ-020 In ACTIVE without a selected ack, the counter SHALL increment each cycle (8 bits).
REQ-021 When the counter equals TIMEOUT-1 and no selected ack is present, the router SHALL go to RESP with the error flag set.
REQ-022 An ack and the timeout in the same cycle SHALL resolve as ack.
REQ-023 In RESP, the router SHALL assert exactly one of m_ack_o or m_err_o for exactly one cycle, then return to IDLE.
REQ-024 m_ack_o and m_err_o SHALL be 0 in every state other than RESP.
REQ-025 If m_cyc_i falls while in ACTIVE, the router SHALL return to IDLE next cycle with no master response, and a late slave ack SHALL be ignored.
REQ-026 m_dat_o SHALL hold its last captured value until the next capture.
REQ-027 Error completions SHALL leave m_dat_o unchanged.
REQ-028 Latency: a slave ack in cycle k SHALL give m_ack_o in cycle k+1; a transfer SHALL take at least 3 cycles from strobe to IDLE.
REQ-029 A fault-path error SHALL appear 1 cycle after the strobe is accepted.
REQ-030 Master strobes arriving in ACTIVE or RESP SHALL not start a new transfer; acceptance happens only in IDLE.

Reset
REQ-031 With rst_i=1 at a clock edge, the router SHALL enter IDLE, clear sel_q and the counter, and set m_dat_o=0, m_ack_o=0, m_err_o=0, s_cyc_o=0, s_stb_o=0 and busy=0.
REQ-032 Reset asserted mid-transfer SHALL abort it with no master response.

Verification
REQ-033 Read: chipselect=7, fault=0 strobe, slave 7 acks on its 2nd ACTIVE cycle with 32'hDEADBEEF -> s_stb_o=16'h0080 for 2 cycles, then m_ack_o=1 for one cycle with m_dat_o=32'hDEADBEEF.
REQ-034 Fault: fault=1 with chipselect=0 -> m_err_o=1 one cycle later, s_stb_o stays 0, and m_dat_o is unchanged.
REQ-035 Timeout: chipselect=5, TIMEOUT=16, no ack -> s_stb_o=16'h0020 for 16 cycles, then m_err_o=1 for one cycle.
REQ-036 Stray ack: chipselect=2 while s_ack_i=16'h0400 -> no response; a later s_ack_i=16'h0004 -> m_ack_o=1.
REQ-037 Abort: m_cyc_i drops in ACTIVE -> IDLE next cycle with no ack or err; rst_i=1 in ACTIVE -> all outputs at their reset values after the edge.
REQ-038 Boundary: ack in the same cycle the counter reaches TIMEOUT-1 -> m_ack_o=1 and m_err_o=0.
